// File: rtl/nt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nt_pkg
// Description : Shared constants and types for the nanotrade order path.
//               It holds the order word layout, the arbiter state encoding
//               and the index of the cancel requester.
// Revision    : 1.0  initial release
// ============================================================================
package nt_pkg;

    // Order word layout: [15:8] price, [7:2] qty, [1] side, [0] type
    localparam int ORDER_W    = 16;
    localparam int PRICE_LSB  = 8;
    localparam int QTY_LSB    = 2;
    localparam int SIDE_BIT   = 1;
    localparam int TYPE_BIT   = 0;

    // The cancel port is always requester 0
    localparam int REQ_CANCEL = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/nt_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : nt_rr_pick
// Description : Combinational round-robin picker. It returns the first
//               asserted request found by scanning from last_grant+1 upward,
//               modulo NUM_REQ. The previous winner is checked last.
// Ports       : req        - request vector
//               last_grant - index of the previous winner
//               grant      - one-hot winner
//               grant_idx  - binary winner index
//               any        - at least one request is asserted
// Revision    : 1.0  initial release
// ============================================================================
module nt_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        // Offsets 1..NUM_REQ, so the previous winner is checked last
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nt_match_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nt_match_arbiter
// Description : Shares the single nanotrade match engine among NUM_REQ order
//               sources. It accepts one order per grant over valid/ready,
//               pulses eng_start, then waits for eng_done or a timeout.
//               On a timeout it pulses eng_abort.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               ena             - enables new grants only
//               req_valid/data  - per-requester order handshake
//               req_ready       - one-hot accept, combinational
//               eng_start/abort - one-cycle engine control pulses
//               eng_data/src    - latched order and its requester id
//               eng_done        - engine completion pulse
//               busy            - not IDLE
//               timeout_err     - sticky timeout flag
//               order_count     - completed orders, wraps at 256
// Revision    : 1.0  initial release
// ============================================================================
module nt_match_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ORDER_W     = nt_pkg::ORDER_W,
    parameter int TIMEOUT_CYC = 64,
    parameter int PRIO_CANCEL = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*ORDER_W-1:0] req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   eng_start,
    output logic [ORDER_W-1:0]     eng_data,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] eng_src,
    input  logic                   eng_done,
    output logic                   eng_abort,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [7:0]             order_count
);

    import nt_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     last_grant;
    logic [CNT_W-1:0]     wait_cnt;
    logic [ORDER_W-1:0]   order_word [NUM_REQ];

    logic [NUM_REQ-1:0]   rr_grant;
    logic [IDX_W-1:0]     rr_idx;
    logic                 rr_any;
    logic                 cancel_wins;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_REQ-1:0]   win_onehot;
    logic                 accept;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign order_word[gi] = req_data[gi*ORDER_W +: ORDER_W];
        end
    endgenerate

    nt_rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req       (req_valid),
        .last_grant(last_grant),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

    // A pending cancel pre-empts the round-robin winner when enabled
    assign cancel_wins = (PRIO_CANCEL != 0) && req_valid[REQ_CANCEL];
    assign win_idx     = cancel_wins ? IDX_W'(REQ_CANCEL) : rr_idx;
    assign win_onehot  = cancel_wins ? (NUM_REQ'(1) << REQ_CANCEL) : rr_grant;

    // rst_n is included so req_ready also reads 0 while reset is held
    assign accept = rst_n && ena && (state == ST_IDLE) && rr_any;
    assign busy   = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        req_ready  = '0;
        eng_start  = 1'b0;
        eng_abort  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    req_ready  = win_onehot;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                eng_start  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the final cycle still counts as done
                if (eng_done) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    eng_abort  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= LAST_INIT;
            wait_cnt    <= '0;
            eng_data    <= '0;
            eng_src     <= '0;
            order_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                eng_data   <= order_word[win_idx];
                eng_src    <= win_idx;
                last_grant <= win_idx;
            end
            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if ((state == ST_WAIT) && eng_done) begin
                order_count <= order_count + 8'd1;
            end
            if (eng_abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nt_match_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nt_match_arbiter
// Description : Directed self-checking bench for nt_match_arbiter. The main
//               instance has cancel priority enabled. A second instance has
//               PRIO_CANCEL=0 and checks the pure round-robin ordering.
// Revision    : 1.0  initial release
// ============================================================================
module tb_nt_match_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        eng_start;
    logic [15:0] eng_data;
    logic [1:0]  eng_src;
    logic        eng_done;
    logic        eng_abort;
    logic        busy;
    logic        timeout_err;
    logic [7:0]  order_count;

    logic [3:0]  rr_valid;
    logic [3:0]  rr_ready;
    logic        rr_start;
    logic [15:0] rr_data;
    logic [1:0]  rr_src;
    logic        rr_done;
    logic        rr_abort;
    logic        rr_busy;
    logic        rr_terr;
    logic [7:0]  rr_count;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_count;
    logic [15:0] words [4];
    logic        flag;

    always #5 clk = ~clk;

    nt_match_arbiter #(
        .NUM_REQ(4), .ORDER_W(16), .TIMEOUT_CYC(64), .PRIO_CANCEL(1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .eng_start(eng_start), .eng_data(eng_data), .eng_src(eng_src),
        .eng_done(eng_done), .eng_abort(eng_abort), .busy(busy),
        .timeout_err(timeout_err), .order_count(order_count)
    );

    nt_match_arbiter #(
        .NUM_REQ(4), .ORDER_W(16), .TIMEOUT_CYC(64), .PRIO_CANCEL(0)
    ) u_dut_rr (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req_valid(rr_valid), .req_data(req_data), .req_ready(rr_ready),
        .eng_start(rr_start), .eng_data(rr_data), .eng_src(rr_src),
        .eng_done(rr_done), .eng_abort(rr_abort), .busy(rr_busy),
        .timeout_err(rr_terr), .order_count(rr_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a negedge in IDLE. It grants one order on the main instance
    // and signals done lat cycles after the start cycle.
    task automatic order_main(input string tag, input logic [3:0] valid,
                              input int exp_src, input int lat);
        req_valid = valid;
        #1;
        check({tag, " ready"}, 32'(req_ready), 32'(1) << exp_src);
        @(negedge clk);
        check({tag, " ready_issue"}, 32'(req_ready), 32'd0);
        req_valid = 4'b0000;
        check({tag, " start"}, 32'(eng_start), 32'd1);
        check({tag, " src"},   32'(eng_src),   32'(exp_src));
        check({tag, " data"},  32'(eng_data),  32'(words[exp_src]));
        repeat (lat) @(negedge clk);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done  = 1'b0;
        exp_count = exp_count + 8'd1;
        check({tag, " count"}, 32'(order_count), 32'(exp_count));
        check({tag, " busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        words[0] = 16'h0155;
        words[1] = 16'h7E22;
        words[2] = 16'hA50D;
        words[3] = 16'hC3F1;
        req_data  = {16'hC3F1, 16'hA50D, 16'h7E22, 16'h0155};
        rst_n     = 1'b0;
        ena       = 1'b0;
        req_valid = 4'b0000;
        rr_valid  = 4'b0000;
        eng_done  = 1'b0;
        rr_done   = 1'b0;
        exp_count = 8'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst busy",  32'(busy),        32'd0);
        check("rst start", 32'(eng_start),   32'd0);
        check("rst abort", 32'(eng_abort),   32'd0);
        check("rst terr",  32'(timeout_err), 32'd0);
        check("rst count", 32'(order_count), 32'd0);
        check("rst data",  32'(eng_data),    32'd0);
        check("rst src",   32'(eng_src),     32'd0);
        rst_n = 1'b1;
        ena   = 1'b1;
        @(negedge clk);

        // Single request, then build last_grant up to 3
        order_main("single", 4'b0100, 2, 5);
        order_main("req3",   4'b1000, 3, 1);
        // Cancel priority: after last_grant=3, and again where RR would pick 1
        order_main("prio03", 4'b1001, 0, 1);
        order_main("prio01", 4'b0011, 0, 1);

        // Round-robin fairness among 1,2,3 with done 2 cycles after start
        for (int i = 0; i < 6; i++) begin
            order_main("rr", 4'b1110, 1 + (i % 3), 2);
        end

        // Done and timeout in the same cycle: done wins
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (64) @(negedge clk);
        eng_done = 1'b1;
        #1;
        check("coinc abort", 32'(eng_abort), 32'd0);
        @(negedge clk);
        eng_done  = 1'b0;
        exp_count = exp_count + 8'd1;
        check("coinc terr",  32'(timeout_err), 32'd0);
        check("coinc count", 32'(order_count), 32'(exp_count));

        // Real timeout: abort in the 64th cycle after ISSUE
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = 4'b0000;
        flag = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k < 64 && eng_abort) flag = 1'b1;
        end
        check("to early abort", 32'(flag),      32'd0);
        check("to abort",       32'(eng_abort), 32'd1);
        check("to busy_wait",   32'(busy),      32'd1);
        @(negedge clk);
        check("to abort_once",  32'(eng_abort),   32'd0);
        check("to busy",        32'(busy),        32'd0);
        check("to terr",        32'(timeout_err), 32'd1);
        check("to count",       32'(order_count), 32'(exp_count));
        order_main("after_to", 4'b0001, 0, 1);
        check("terr sticky", 32'(timeout_err), 32'd1);

        // ena dropped during WAIT
        req_valid = 4'b0010;
        @(negedge clk);
        check("ena src", 32'(eng_src), 32'd1);
        req_valid = 4'b1000;
        ena       = 1'b0;
        @(negedge clk);
        check("ena ready_wait", 32'(req_ready), 32'd0);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done  = 1'b0;
        exp_count = exp_count + 8'd1;
        check("ena count",      32'(order_count), 32'(exp_count));
        check("ena ready_idle", 32'(req_ready),   32'd0);
        @(negedge clk);
        check("ena ready_idle2", 32'(req_ready), 32'd0);
        check("ena busy",        32'(busy),      32'd0);
        ena = 1'b1;
        order_main("ena_back", 4'b1000, 3, 1);

        // Counter wrap
        begin
            int n;
            n = 256 - int'(exp_count);
            for (int i = 0; i < n; i++) begin
                order_main("wrap", 4'b0001, 0, 1);
            end
        end
        check("wrap zero", 32'(order_count), 32'd0);

        // Raise timeout_err again so the reset clear is observable
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (65) @(negedge clk);
        check("terr before rst", 32'(timeout_err), 32'd1);

        // Reset in the middle of WAIT
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (3) @(negedge clk);
        check("mid busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst busy",  32'(busy),        32'd0);
        check("mrst start", 32'(eng_start),   32'd0);
        check("mrst abort", 32'(eng_abort),   32'd0);
        check("mrst terr",  32'(timeout_err), 32'd0);
        check("mrst count", 32'(order_count), 32'd0);
        flag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (eng_abort || eng_start) flag = 1'b1;
        end
        check("mrst no_pulse", 32'(flag), 32'd0);
        rst_n     = 1'b1;
        exp_count = 8'd0;
        @(negedge clk);

        // Pure round-robin instance: last_grant=0 means 3 beats 0
        rr_valid = 4'b0001;
        #1;
        check("rr0 ready", 32'(rr_ready), 32'b0001);
        @(negedge clk);
        rr_valid = 4'b0000;
        check("rr0 src", 32'(rr_src), 32'd0);
        @(negedge clk);
        rr_done = 1'b1;
        @(negedge clk);
        rr_done = 1'b0;
        check("rr0 count", 32'(rr_count), 32'd1);
        rr_valid = 4'b1001;
        #1;
        check("rr03 ready", 32'(rr_ready), 32'b1000);
        @(negedge clk);
        check("rr03 src",  32'(rr_src),  32'd3);
        check("rr03 data", 32'(rr_data), 32'hC3F1);
        @(negedge clk);
        rr_done = 1'b1;
        @(negedge clk);
        rr_done = 1'b0;
        #1;
        check("rr30 ready", 32'(rr_ready), 32'b0001);
        rr_valid = 4'b0000;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
